// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default counter width for the timer.
package timer_pkg;
   localparam int CNT_W_DEF = 32;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/timer_count_unit_if.sv
// timer_count_unit_if: control/status bundle between timer and its host.
interface timer_count_unit_if
   import timer_pkg::*;
   #(parameter int CNT_W = CNT_W_DEF);
   logic             tick;
   logic             start;
   logic             stop;
   logic             periodic;
   logic [CNT_W-1:0] reload;
   logic [CNT_W-1:0] compare;
   logic             irq_en;
   logic             irq_clr;
   logic [CNT_W-1:0] count;
   logic             running;
   logic             expire;
   logic             match;
   logic             pwm_out;
   logic             irq;
   modport master (
      output tick, start, stop, periodic, reload, compare, irq_en, irq_clr,
      input  count, running, expire, match, pwm_out, irq
   );
   modport slave (
      input  tick, start, stop, periodic, reload, compare, irq_en, irq_clr,
      output count, running, expire, match, pwm_out, irq
   );
endinterface

// File: rtl/timer_irq_latch.sv
// timer_irq_latch: sticky interrupt status, set dominating clear, masked output.
module timer_irq_latch (
   input  logic clk,
   input  logic rst_n,
   input  logic set,
   input  logic clr,
   input  logic en,
   output logic irq
);
   logic status;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) status <= 1'b0;
      else        status <= set ? 1'b1 : (clr ? 1'b0 : status);
   assign irq = status & en;
endmodule

// File: rtl/timer_count_unit.sv
// timer_count_unit: down-counting one-shot/periodic timer with compare match,
// PWM output and a sticky, maskable expiry interrupt.
module timer_count_unit
   import timer_pkg::*;
   #(parameter int CNT_W = CNT_W_DEF)
   (
   input logic clk,
   input logic rst_n,
   timer_count_unit_if.slave bus
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             expire_q, expire_d, match_q, match_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         expire_q <= 1'b0;
         match_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         expire_q <= expire_d;
         match_q  <= match_d;
      end
   // Expiry at zero never wraps: it either reloads or parks at zero.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      expire_d = 1'b0;
      match_d  = 1'b0;
      if (bus.stop) state_d = IDLE;
      else if (bus.start) begin
         state_d = RUN;
         count_d = bus.reload;
      end else if (state_q == RUN && bus.tick) begin
         match_d  = count_q == bus.compare;
         expire_d = count_q == '0;
         count_d  = expire_d ? (bus.periodic ? bus.reload : count_q) : count_q - CNT_W'(1);
         state_d  = (expire_d && !bus.periodic) ? DONE : RUN;
      end
   end
   assign bus.count   = count_q;
   assign bus.expire  = expire_q;
   assign bus.match   = match_q;
   assign bus.running = state_q == RUN;
   assign bus.pwm_out = bus.running && (count_q > bus.compare);
   timer_irq_latch u_irq (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (expire_q),
      .clr   (bus.irq_clr),
      .en    (bus.irq_en),
      .irq   (bus.irq)
   );
endmodule
